// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared widths, source identifiers and state encoding for the
//               register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    // Default result word and register index widths
    localparam int unsigned c_data_w = 32;
    localparam int unsigned c_addr_w = 5;

    // Source identifiers, also used as the mux select and the wb_src value
    localparam logic [0:0] c_src_alu = 1'b0;
    localparam logic [0:0] c_src_mem = 1'b1;

    // Output-register state; the state bit is exactly wb_valid
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter_move_mux.sv
`default_nettype none
// ============================================================================
// Module      : move_mux
// Description : 2:1 data-select mux; select = 0 passes inp0, 1 passes inp1.
// Revision    : 1.0 - initial release
// ============================================================================
module move_mux
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = c_data_w
) (
    input  logic [WIDTH-1:0] inp0,
    input  logic [WIDTH-1:0] inp1,
    input  logic             select,
    output logic [WIDTH-1:0] outp
);

    // Pure combinational select between the two operands
    always_comb begin
        outp = (select == c_src_mem) ? inp1 : inp0;
    end

endmodule : move_mux
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Round-robin arbiter sharing the register-file write port
//               between the ALU result path (source 0) and the memory-load
//               path (source 1), with a one-entry registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = c_data_w,
    parameter int unsigned ADDR_W = c_addr_w
) (
    input  logic              clk,
    input  logic              reset,
    // Source 0: ALU result
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s0_data,
    input  logic [ADDR_W-1:0] s0_rd,
    // Source 1: memory load
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic [ADDR_W-1:0] s1_rd,
    // Register-file write port
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_src
);

    logic [0:0]        r_state;
    logic              r_last;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_src;

    logic              w_can_accept;
    logic              w_any_valid;
    logic              w_winner;
    logic              w_grant;
    logic              w_store;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_mux_data;

    // Pick the winner: the non-last source on contention, else whoever is valid
    always_comb begin
        w_any_valid  = s0_valid | s1_valid;
        w_can_accept = (r_state == c_st_empty) | wb_ready;
        if (s0_valid && s1_valid) begin
            w_winner = ~r_last;
        end else if (s1_valid) begin
            w_winner = c_src_mem;
        end else begin
            w_winner = c_src_alu;
        end
        w_grant  = w_can_accept & w_any_valid;
        s0_ready = w_grant & (w_winner == c_src_alu);
        s1_ready = w_grant & (w_winner == c_src_mem);
        w_rd     = (w_winner == c_src_mem) ? s1_rd : s0_rd;
        // Writes to register 0 are acknowledged but never stored
        w_store  = w_grant & (w_rd != '0);
    end

    move_mux #(
        .WIDTH (DATA_W)
    ) u_move_mux (
        .inp0   (s0_data),
        .inp1   (s1_data),
        .select (w_winner),
        .outp   (w_mux_data)
    );

    // Output register, state and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_empty;
            r_last    <= c_src_mem;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_src  <= c_src_alu;
        end else begin
            if (w_grant) begin
                r_last <= w_winner;
            end
            if (w_store) begin
                // Covers both the empty fill and the back-to-back replace
                r_state   <= c_st_full;
                r_wb_addr <= w_rd;
                r_wb_data <= w_mux_data;
                r_wb_src  <= w_winner;
            end else if ((r_state == c_st_full) && wb_ready) begin
                r_state <= c_st_empty;
            end
        end
    end

    assign wb_valid = (r_state == c_st_full);
    assign wb_addr  = r_wb_addr;
    assign wb_data  = r_wb_data;
    assign wb_src   = r_wb_src;

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [31:0] s0_data, s1_data;
    logic [4:0]  s0_rd, s1_rd;
    logic        wb_valid, wb_ready, wb_src;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_data  (s0_data),
        .s0_rd    (s0_rd),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_data  (s1_data),
        .s1_rd    (s1_rd),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_src   (wb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are looked at 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [4:0] a,
                          input logic [31:0] d, input logic s);
        chk({tag, ".valid"}, {63'd0, wb_valid}, {63'd0, v});
        chk({tag, ".addr"},  {59'd0, wb_addr},  {59'd0, a});
        chk({tag, ".data"},  {32'd0, wb_data},  {32'd0, d});
        chk({tag, ".src"},   {63'd0, wb_src},   {63'd0, s});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".s0_ready"}, {63'd0, s0_ready}, {63'd0, r0});
        chk({tag, ".s1_ready"}, {63'd0, s1_ready}, {63'd0, r1});
    endtask

    initial begin
        reset = 1'b1; wb_ready = 1'b0;
        s0_valid = 1'b0; s0_data = '0; s0_rd = '0;
        s1_valid = 1'b0; s1_data = '0; s1_rd = '0;
        tick(); tick();
        reset = 1'b0;
        chk_wb("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        chk_rdy("idle", 1'b0, 1'b0);

        // Single ALU result, visible one cycle after the grant
        s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'h0000_00AA; wb_ready = 1'b1;
        chk_rdy("single", 1'b1, 1'b0);
        tick();
        s0_valid = 1'b0;
        chk_wb("single", 1'b1, 5'd3, 32'hAA, 1'b0);
        tick();
        chk_wb("drain1", 1'b0, 5'd3, 32'hAA, 1'b0);

        // Contention from a fresh reset alternates 0,1,0,1
        reset = 1'b1; tick(); reset = 1'b0;
        s0_valid = 1'b1; s0_rd = 5'd5; s0_data = 32'h11;
        s1_valid = 1'b1; s1_rd = 5'd6; s1_data = 32'h22;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_rdy("rr", (i % 2) == 0, (i % 2) == 1);
            tick();
            if ((i % 2) == 0) chk_wb("rr", 1'b1, 5'd5, 32'h11, 1'b0);
            else              chk_wb("rr", 1'b1, 5'd6, 32'h22, 1'b1);
        end

        // FULL and stalled: source 1 waits, output word is stable
        s0_valid = 1'b0;
        s1_rd = 5'd9; s1_data = 32'h33; wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("stall", 1'b0, 1'b0);
            tick();
            chk_wb("stall", 1'b1, 5'd6, 32'h22, 1'b1);
        end
        wb_ready = 1'b1;
        chk_rdy("unstall", 1'b0, 1'b1);
        tick();
        chk_wb("unstall", 1'b1, 5'd9, 32'h33, 1'b1);

        // Back-to-back replace by source 0 leaves last = 0
        s1_valid = 1'b0;
        s0_valid = 1'b1; s0_rd = 5'd2; s0_data = 32'h66;
        tick();
        s0_valid = 1'b0;
        chk_wb("b2b_s0", 1'b1, 5'd2, 32'h66, 1'b0);
        tick();
        chk_wb("drain2", 1'b0, 5'd2, 32'h66, 1'b0);

        // rd 0 from source 1: acknowledged, not stored, pointer still moves
        s1_valid = 1'b1; s1_rd = 5'd0; s1_data = 32'hDEAD_BEEF;
        chk_rdy("rd0", 1'b0, 1'b1);
        tick();
        chk_wb("rd0", 1'b0, 5'd2, 32'h66, 1'b0);
        s0_valid = 1'b1; s0_rd = 5'd4; s0_data = 32'h44;
        s1_rd = 5'd10; s1_data = 32'h55;
        chk_rdy("after_rd0", 1'b1, 1'b0);
        tick();
        chk_wb("after_rd0", 1'b1, 5'd4, 32'h44, 1'b0);

        // rd 0 grant while FULL with wb_ready drains to EMPTY
        s0_valid = 1'b0; s1_rd = 5'd0;
        chk_rdy("rd0_full", 1'b0, 1'b1);
        tick();
        s1_valid = 1'b0;
        chk_wb("rd0_full", 1'b0, 5'd4, 32'h44, 1'b0);

        // Reset while FULL discards the held write
        s0_valid = 1'b1; s0_rd = 5'd7; s0_data = 32'h77; wb_ready = 1'b0;
        tick();
        s0_valid = 1'b0;
        chk_wb("pre_rst", 1'b1, 5'd7, 32'h77, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_wb("mid_rst", 1'b0, 5'd0, 32'h0, 1'b0);
        wb_ready = 1'b1;
        tick();
        chk_wb("post_rst", 1'b0, 5'd0, 32'h0, 1'b0);

        // Streaming: one write per cycle, no bubbles
        for (int i = 1; i <= 8; i++) begin
            s0_valid = 1'b1; s0_rd = 5'(i); s0_data = 32'h100 + 32'(i);
            tick();
            chk_wb("stream", 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0);
        end
        s0_valid = 1'b0;
        tick();
        chk_wb("stream_end", 1'b0, 5'd8, 32'h108, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_port_arbiter
`default_nettype wire
